// File: rtl/rgb_yuv_pkg.sv
// rgb_yuv_pkg: fixed-point constants and helpers shared by the RGB<->YUV blocks
package rgb_yuv_pkg;
  localparam int FRAC_BITS = 4;
  localparam int Y_R = 5;
  localparam int Y_G = 9;
  localparam int Y_B = 2;
  localparam int U_DB = 8;
  localparam int V_DR = 10;
  localparam int RND = 8;
  function automatic logic [7:0] sat8_signed(input logic signed [12:0] x);
    return (x > 13'sd127) ? 8'h7f : (x < -13'sd128) ? 8'h80 : x[7:0];
  endfunction
endpackage

// File: rtl/rgb_yuv_pipe_stage.sv
// rgb_yuv_pipe_stage: valid/data register that loads only when the pipe advances
module rgb_yuv_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  // bubbles shift like real pixels; everything holds while stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      out_data <= in_data;
    end
endmodule

// File: rtl/rgb_to_yuv_stream.sv
// rgb_to_yuv_stream: 3-stage handshaked RGB to YUV converter (nibble fixed point)
module rgb_to_yuv_stream
  import rgb_yuv_pkg::*;
#(
  parameter bit LAST_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_y,
  output logic [7:0] out_u,
  output logic [7:0] out_v,
  output logic       out_last
);
  logic               advance;
  logic [11:0]        ysum;
  logic               s1_valid, s2_valid, s3_valid;
  logic [28:0]        s1_d;
  logic [26:0]        s2_d;
  logic [24:0]        s3_d;
  logic [8:0]         yr9;
  logic [7:0]         yr;
  logic signed [8:0]  db, dr, s2_db, s2_dr;
  logic signed [12:0] db_x, dr_x, up, vp, up_r, vp_r;

  // the whole pipe stalls only when the last stage holds a pixel nobody takes
  assign advance = !(s3_valid && !out_ready);
  assign in_ready = advance;

  // S1 input: weighted luma sum in 8.4, R and B carried for the chroma diffs
  always_comb ysum = 12'(Y_R * int'(in_r) + Y_G * int'(in_g) + Y_B * int'(in_b));

  rgb_yuv_pipe_stage #(.W(29)) u_s1 (
    .clk(clk), .rst_n(rst_n), .adv(advance), .in_valid(in_valid),
    .in_data({in_last & LAST_EN, in_r, in_b, ysum}),
    .out_valid(s1_valid), .out_data(s1_d)
  );

  // S2 input: round luma half-up, clamp, then form B-Y and R-Y
  always_comb begin
    yr9 = 9'(s1_d[11:4]) + 9'(s1_d[3]);
    yr = yr9[8] ? 8'hff : yr9[7:0];
    db = 9'(s1_d[19:12]) - 9'(yr);
    dr = 9'(s1_d[27:20]) - 9'(yr);
  end

  rgb_yuv_pipe_stage #(.W(27)) u_s2 (
    .clk(clk), .rst_n(rst_n), .adv(advance), .in_valid(s1_valid),
    .in_data({s1_d[28], yr, db, dr}),
    .out_valid(s2_valid), .out_data(s2_d)
  );

  // S3 input: scale the diffs, round half toward +inf, saturate to int8
  always_comb begin
    s2_db = s2_d[17:9];
    s2_dr = s2_d[8:0];
    db_x = 13'(s2_db);
    dr_x = 13'(s2_dr);
    up = db_x * 13'(U_DB);
    vp = dr_x * 13'(V_DR);
    up_r = (up + 13'(RND)) >>> FRAC_BITS;
    vp_r = (vp + 13'(RND)) >>> FRAC_BITS;
  end

  rgb_yuv_pipe_stage #(.W(25)) u_s3 (
    .clk(clk), .rst_n(rst_n), .adv(advance), .in_valid(s2_valid),
    .in_data({s2_d[26], s2_d[25:18], sat8_signed(up_r), sat8_signed(vp_r)}),
    .out_valid(s3_valid), .out_data(s3_d)
  );

  assign out_valid = s3_valid;
  assign out_last = s3_d[24];
  assign out_y = s3_d[23:16];
  assign out_u = s3_d[15:8];
  assign out_v = s3_d[7:0];
endmodule

// File: tb/tb_rgb_to_yuv_stream.sv
// tb_rgb_to_yuv_stream: randomized scoreboard bench for rgb_to_yuv_stream
module tb_rgb_to_yuv_stream;
  logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic in_ready, out_valid, out_last;
  logic [7:0] out_y, out_u, out_v;

  typedef struct {
    logic [7:0] y, u, v;
    logic last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  bit chk_lat = 0, stall = 0, tog = 0;
  logic [24:0] held;

  rgb_to_yuv_stream #(.LAST_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_u(out_u), .out_v(out_v), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int fdiv16(int a);
    return a >= 0 ? a / 16 : -((-a + 15) / 16);
  endfunction

  function automatic int clampi(int x, int lo, int hi);
    return x < lo ? lo : (x > hi ? hi : x);
  endfunction

  // reference: Y = round(0.3125R+0.5625G+0.125B), U = round(0.5(B-Y)), V = round(0.625(R-Y))
  function automatic exp_t model(int r, int g, int b, logic l);
    exp_t e;
    int y, u, v;
    y = clampi(fdiv16(5 * r + 9 * g + 2 * b + 8), 0, 255);
    u = clampi(fdiv16(8 * (b - y) + 8), -128, 127);
    v = clampi(fdiv16(10 * (r - y) + 8), -128, 127);
    e.y = 8'(y);
    e.u = 8'(u);
    e.v = 8'(v);
    e.last = l;
    e.cyc = 0;
    return e;
  endfunction

  // monitor: stall stability, output scoreboard, input capture
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) stall = 0;
    else begin
      if (stall) begin
        total++;
        if (!out_valid || {out_last, out_y, out_u, out_v} !== held) begin
          bad++;
          $display("FAIL hold: got valid=%b data=%h, required valid=1 data=%h", out_valid,
                   {out_last, out_y, out_u, out_v}, held);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected: got y=%h u=%h v=%h last=%b, required no output", out_y, out_u,
                   out_v, out_last);
        end else begin
          e = q.pop_front();
          if (out_y !== e.y || out_u !== e.u || out_v !== e.v || out_last !== e.last) begin
            bad++;
            $display("FAIL pixel: got y=%h u=%h v=%h last=%b, required y=%h u=%h v=%h last=%b",
                     out_y, out_u, out_v, out_last, e.y, e.u, e.v, e.last);
          end
          if (chk_lat) begin
            total++;
            if (cyc - e.cyc != 3) begin
              bad++;
              $display("FAIL latency: got %0d, required 3", cyc - e.cyc);
            end
          end
        end
      end
      stall = out_valid && !out_ready;
      held = {out_last, out_y, out_u, out_v};
      if (in_valid && in_ready) begin
        e = model(int'(in_r), int'(in_g), int'(in_b), in_last);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [7:0] r, g, b, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_r = r;
    in_g = g;
    in_b = b;
    in_last = l;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send: got in_ready=0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
  endtask

  task automatic rand_stream(input int cnt, input int last_at);
    tog = 1;
    fork
      while (tog) begin
        @(posedge clk);
        #1;
        out_ready = $urandom_range(0, 1) == 1;
      end
      begin
        for (int i = 0; i < cnt; i++) begin
          send(8'($urandom), 8'($urandom), 8'($urandom),
               last_at < 0 ? ($urandom_range(0, 3) == 0) : (i == last_at));
          repeat ($urandom_range(0, 1)) @(posedge clk);
          #1;
        end
        tog = 0;
      end
    join
    #1 out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, out_y, out_u, out_v} !== '0) begin
      bad++;
      $display("FAIL reset: got %h, required 0", {out_valid, out_last, out_y, out_u, out_v});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %b, required 1", in_ready);
    end
    chk_lat = 1;
    send(8'd0, 8'd0, 8'd0, 1'b0);
    drain();
    send(8'd255, 8'd255, 8'd255, 1'b0);
    drain();
    send(8'd255, 8'd0, 8'd0, 1'b0);
    send(8'd0, 8'd0, 8'd255, 1'b0);
    send(8'd0, 8'd255, 8'd0, 1'b1);
    drain();
    chk_lat = 0;
    send(8'd10, 8'd20, 8'd30, 1'b0);
    send(8'd200, 8'd100, 8'd50, 1'b0);
    send(8'd1, 8'd254, 8'd128, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_ready: got %b, required 0", in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'd77, 8'd88, 8'd99, 1'b1);
    drain();
    rand_stream(8, 3);
    rand_stream(300, -1);
    send(8'd40, 8'd50, 8'd60, 1'b0);
    send(8'd70, 8'd80, 8'd90, 1'b1);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_last, out_y, out_u, out_v} !== '0) begin
      bad++;
      $display("FAIL midreset: got %h, required 0", {out_valid, out_last, out_y, out_u, out_v});
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_lat = 1;
    send(8'd255, 8'd0, 8'd0, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
